uart_tx_feeder: RTL and testbench
=================================

Name: uart_tx_feeder

Overview:
- Transmit-side byte buffer and launcher that sits directly upstream of the UART transmitter.
- Accepts bytes from FPGA logic into a DEPTH-entry FIFO.
- Drives the transmitter's `data_in`/`send` inputs and paces launches on its `busy` output, so producers can burst bytes without watching the serial line.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of two, minimum 2.
- ADDR_WIDTH, 4, log2(DEPTH); pointer width.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_data  input  8  byte to enqueue.
- wr_en  input  1  enqueue strobe, sampled each rising edge.
- clear_overflow  input  1  clears sticky overflow flag.
- full  output  1  FIFO holds DEPTH bytes.
- empty  output  1  FIFO holds 0 bytes.
- level  output  ADDR_WIDTH+1  bytes currently held in the FIFO, excluding the byte being transmitted.
- overflow  output  1  sticky; a write was dropped.
- tx_data  output  8  to transmitter `data_in`.
- tx_send  output  1  to transmitter `send`.
- tx_busy  input  1  from transmitter `busy`.

Behaviour:
- Reset values (asynchronous, immediate): level=0, empty=1, full=0, overflow=0, tx_data=8'h00, tx_send=0, FSM=IDLE, read/write pointers=0. FIFO contents are discarded.
- Reset mid-transmission: tx_send drops at once. The transmitter is reset by the same net.
- Flags: full and empty are decoded from the registered level, never from combinational inputs.
- Writes:
  - wr_en=1 and full=0: store wr_data at the write pointer; the write pointer increments modulo DEPTH.
  - wr_en=1 and full=1: byte dropped and overflow set to 1. This applies even if a pop occurs in the same cycle.
- Overflow flag: clear_overflow=1 clears it next edge. If a drop and clear_overflow occur in the same cycle, set wins.
- Level update:
  - Write-only cycle: +1.
  - Pop-only cycle: -1.
  - Accepted write and pop in the same cycle: unchanged.
  - Level never exceeds DEPTH and never underflows.
- FSM, three states:
  - IDLE: if empty=0 and tx_busy=0, pop the head byte into the tx_data register (read pointer +1 mod DEPTH, level -1) and go to SEND. Otherwise stay.
  - SEND: tx_send=1. Hold until tx_busy is sampled 1, then go to WAIT with tx_send=0 from that edge. No timeout.
  - WAIT: tx_send=0. When tx_busy is sampled 0, go to IDLE.
- tx_send is registered: high exactly while in SEND.
- tx_data changes only on the IDLE->SEND pop edge and is stable through SEND and WAIT.
- Latency, empty FIFO and idle transmitter:
  - wr_en sampled at edge E0.
  - empty=0 after E0.
  - Pop at E1; tx_send=1 after E1.
- Back-to-back: after tx_busy falls (sampled at edge Ek), the FSM is in IDLE for one cycle, pops at Ek+1, and tx_send rises after Ek+1.
- If tx_busy is already 1 in IDLE (external activity), no pop occurs until it is sampled 0.
- Write into an empty FIFO in the same cycle the FSM is in IDLE: the byte is not popped until the next edge. There is no fall-through.
- One byte in flight at most; the FIFO preserves strict arrival order.

Test Plan:
- Reset, then a single write of wr_data=8'hA5 with a transmitter model (busy rises 1 cycle after send, lasts 10 bit-times):
  - Required: tx_send high 2 cycles after the wr_en edge, with tx_data=8'hA5.
  - tx_send low the cycle after busy is seen.
  - level returns to 0, empty=1.
- Burst of 16 writes 8'h00..8'h0F in 16 consecutive cycles, transmitter busy:
  - Required: bytes emerge on tx_data in order 00..0F, one launch per busy low period.
  - full never falsely asserts after the first pop.
- Fill to 16 with busy held high, then write 8'h77:
  - Required: full=1, level=16, overflow=1, 8'h77 never transmitted.
  - Then clear_overflow=1 gives overflow=0 next cycle.
  - Same-cycle drop plus clear leaves overflow=1.
- At full, assert wr_en in the same cycle busy falls and a pop occurs:
  - Required: the write is still dropped, overflow=1, level becomes 15.
  - Wrap: 40 bytes streamed through, all received in order.
- Assert reset mid-transmission with 5 bytes queued:
  - Required: tx_send, level and overflow go to 0 immediately with no clock edge.
  - No queued byte is sent after reset release.
  - A new write launches normally.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launcher feeding a UART transmitter; one byte in flight,
// launches paced by the transmitter's busy handshake.
//
// state | meaning
// IDLE  | no byte in flight; pop head when FIFO non-empty and busy low
// SEND  | tx_send high; waiting for the transmitter to raise busy
// WAIT  | transmitter shifting; waiting for busy to fall
module uart_tx_feeder #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  input  logic                  clear_overflow,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic [7:0]            tx_data,
  output logic                  tx_send,
  input  logic                  tx_busy
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  localparam logic [ADDR_WIDTH:0]   FULL_LVL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LVL_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  state_t                state, state_nxt;
  logic [7:0]            mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  wr_ok, pop;

  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
  assign wr_ok = wr_en && !full;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: if (!empty && !tx_busy) begin
        pop       = 1'b1;
        state_nxt = SEND;
      end
      SEND: if (tx_busy) state_nxt = WAIT;
      WAIT: if (!tx_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tx_send <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      state   <= state_nxt;
      tx_send <= (state_nxt == SEND);
      if (pop) tx_data <= mem[rd_ptr];
    end
  end

  // Storage has no reset; pointers and level define what is valid.
  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_ok, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (wr_en && full)       overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized bench: transaction-level queue model of the feeder plus a
// behavioural UART transmitter that answers tx_send with a busy pulse.
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       clear_overflow = 1'b0;
  logic       full, empty, overflow, tx_send;
  logic [4:0] level;
  logic [7:0] tx_data;
  logic       tx_busy = 1'b0;

  uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_WIDTH(4)) dut (
    .clock(clock), .reset(reset), .wr_data(wr_data), .wr_en(wr_en),
    .clear_overflow(clear_overflow), .full(full), .empty(empty),
    .level(level), .overflow(overflow), .tx_data(tx_data),
    .tx_send(tx_send), .tx_busy(tx_busy)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic [7:0] q[$];
  logic [7:0] sent[$];
  logic       m_in_flight = 0, m_seen_busy = 0, m_ovf = 0;
  logic [7:0] m_data = 8'h00;

  // transmitter model
  logic force_busy = 0, x_busy = 0, x_pend = 0;
  int   x_cnt = 0, bit_len = 10;

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic upd_busy();
    tx_busy = force_busy | x_busy;
  endtask

  task automatic step();
    logic w, c, b, launch, full_pre;
    logic [7:0] d;
    w = wr_en; d = wr_data; c = clear_overflow; b = tx_busy;
    @(posedge clock); #1;
    launch   = !m_in_flight && (q.size() > 0) && !b;
    full_pre = (q.size() == DEPTH);
    if (m_in_flight) begin
      if (!m_seen_busy && b)     m_seen_busy = 1;
      else if (m_seen_busy && !b) m_in_flight = 0;
    end
    if (launch) begin
      m_data = q.pop_front();
      m_in_flight = 1;
      m_seen_busy = 0;
      sent.push_back(m_data);
    end
    if (w && !full_pre) q.push_back(d);
    if (w && full_pre) m_ovf = 1;
    else if (c)        m_ovf = 0;
    check_val("tx_send", tx_send, m_in_flight && !m_seen_busy);
    check_val("tx_data", tx_data, m_data);
    check_val("level", level, q.size());
    check_val("full", full, q.size() == DEPTH);
    check_val("empty", empty, q.size() == 0);
    check_val("overflow", overflow, m_ovf);
    if (x_pend) begin
      x_busy = 1; x_cnt = bit_len; x_pend = 0;
    end else if (x_busy) begin
      x_cnt--;
      if (x_cnt == 0) x_busy = 0;
    end else if (tx_send) begin
      x_pend = 1;
    end
    upd_busy();
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (q.size() == 0 && !m_in_flight && !tx_busy) break;
      step();
    end
    check_val("drain_done", (q.size() == 0) && !m_in_flight, 1);
  endtask

  task automatic model_reset();
    q.delete();
    m_in_flight = 0; m_seen_busy = 0; m_ovf = 0; m_data = 8'h00;
    x_busy = 0; x_pend = 0; x_cnt = 0; force_busy = 0;
    upd_busy();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int mark, found, base, written;
    // reset
    #12;
    check_val("rst_level", level, 0);
    check_val("rst_empty", empty, 1);
    check_val("rst_full", full, 0);
    check_val("rst_send", tx_send, 0);
    check_val("rst_data", tx_data, 8'h00);
    @(negedge clock); reset = 0;

    // single byte, latency
    @(posedge clock); #1;
    bit_len = 10;
    wr_en = 1; wr_data = 8'hA5;
    step();
    wr_en = 0;
    check_val("a5_nonempty", empty, 0);
    step();
    check_val("a5_send", tx_send, 1);
    check_val("a5_data", tx_data, 8'hA5);
    drain();
    check_val("a5_level", level, 0);
    check_val("a5_empty", empty, 1);

    // burst 00..0F
    mark = sent.size();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; wr_data = 8'(i);
      step();
    end
    wr_en = 0;
    drain();
    check_val("burst_count", sent.size() - mark, 16);
    for (int i = 0; i < 16 && mark + i < sent.size(); i++)
      check_val("burst_order", sent[mark + i], 8'(i));

    // fill with busy held, overflow set/clear
    mark = sent.size();
    force_busy = 1; upd_busy();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; wr_data = 8'h20 + 8'(i);
      step();
    end
    wr_data = 8'h77;
    step();
    wr_en = 0;
    check_val("fill_full", full, 1);
    check_val("fill_level", level, 16);
    check_val("fill_ovf", overflow, 1);
    clear_overflow = 1;
    step();
    check_val("clr_ovf", overflow, 0);
    wr_en = 1;
    step();
    check_val("drop_clr_ovf", overflow, 1);
    clear_overflow = 0;
    step();
    // write at full in the cycle busy falls and a pop happens
    force_busy = 0; upd_busy();
    step();
    wr_en = 0;
    check_val("pop_drop_ovf", overflow, 1);
    check_val("pop_drop_level", level, 15);
    check_val("pop_drop_send", tx_send, 1);
    drain();
    found = 0;
    for (int i = mark; i < sent.size(); i++) if (sent[i] == 8'h77) found++;
    check_val("no_77", found, 0);
    check_val("fill_count", sent.size() - mark, 16);

    // wrap: 40 random bytes with random pacing
    base = sent.size();
    written = 0;
    for (int i = 0; i < 4000 && written < 40; i++) begin
      bit_len = $urandom_range(1, 6);
      clear_overflow = ($urandom_range(0, 7) == 0);
      wr_en = ($urandom_range(0, 1) == 1) && (q.size() < DEPTH);
      wr_data = 8'($urandom);
      if (wr_en) written++;
      step();
    end
    wr_en = 0; clear_overflow = 0;
    drain();
    check_val("wrap_count", sent.size() - base, 40);

    // reset mid-transmission with 5 queued
    bit_len = 10;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1; wr_data = 8'h40 + 8'(i);
      step();
    end
    wr_en = 0;
    step(); step();
    check_val("pre_rst_level", level, 5);
    #2; reset = 1; #1;
    check_val("arst_send", tx_send, 0);
    check_val("arst_level", level, 0);
    check_val("arst_ovf", overflow, 0);
    model_reset();
    @(posedge clock); #2; reset = 0;
    mark = sent.size();
    for (int i = 0; i < 20; i++) step();
    check_val("post_rst_none", sent.size() - mark, 0);
    wr_en = 1; wr_data = 8'h3C;
    step();
    wr_en = 0;
    step();
    check_val("post_rst_send", tx_send, 1);
    check_val("post_rst_data", tx_data, 8'h3C);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
